// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: mode sequencer for the mm:ss stopwatch counter.
// Turns debounced pause/clear pulses and the sel/adj switches into
// single-cycle strobes for the counter datapath (count, adjust, clear).
// All outputs are registered, so a strobe shows up one cycle after the
// condition that enables it.
// Optional feature: define STOPWATCH_BLINK_EN to blink the field being adjusted.
module stopwatch_ctrl #(
    parameter int TICK_DIV  = 2,
    parameter int ADJ_DIV   = 1,
    parameter int BLINK_DIV = 1
) (
    input  logic       clkAdj,
    input  logic       rst,
    input  logic       pause_p,
    input  logic       clear_p,
    input  logic       sel,
    input  logic       adj,
    output logic       cnt_inc,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       clr,
    output logic       paused,
    output logic [1:0] state,
    output logic       blink_min,
    output logic       blink_sec
);

    typedef enum logic [1:0] {
        S_RUN   = 2'b00,
        S_PAUSE = 2'b01,
        S_ADJ   = 2'b10,
        S_CLR   = 2'b11
    } state_t;

    // Counter widths; keep at least one bit when a divider is 1.
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (ADJ_DIV  > 1) ? $clog2(ADJ_DIV)  : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ADJ_LAST  = AW'(ADJ_DIV - 1);

    state_t          r_state;
    logic            r_paused;
    logic [TW-1:0]   r_tick_cnt;
    logic [AW-1:0]   r_adj_cnt;
    logic            r_sel_q;
    logic            r_cnt_inc;
    logic            r_inc_sec;
    logic            r_inc_min;
    logic            r_clr;

    state_t          w_state_nxt;
    logic            w_pause_tog;
    logic            w_paused_nxt;
    logic            w_sel_chg;
    logic [AW-1:0]   w_adj_eff;
    logic [TW-1:0]   w_tick_nxt;
    logic [AW-1:0]   w_adj_nxt;
    logic            w_cnt_inc_nxt;
    logic            w_inc_sec_nxt;
    logic            w_inc_min_nxt;
    logic            w_clr_nxt;

    // pause_p only counts in RUN/PAUSE and loses to a simultaneous clear_p.
    assign w_pause_tog  = pause_p & ~clear_p & ((r_state == S_RUN) | (r_state == S_PAUSE));
    assign w_paused_nxt = r_paused ^ w_pause_tog;

    // A field switch restarts the adjust divider in the same cycle, so the
    // new field's first increment lands ADJ_DIV cycles after the switch.
    assign w_sel_chg = (sel != r_sel_q);
    assign w_adj_eff = w_sel_chg ? '0 : r_adj_cnt;

    // Next-state, divider and strobe decode; priority is clear_p > adj > pause flag.
    always_comb begin
        w_state_nxt   = r_state;
        w_tick_nxt    = r_tick_cnt;
        w_adj_nxt     = '0;
        w_cnt_inc_nxt = 1'b0;
        w_inc_sec_nxt = 1'b0;
        w_inc_min_nxt = 1'b0;
        w_clr_nxt     = 1'b0;

        if (clear_p) begin
            w_state_nxt = S_CLR;
            w_clr_nxt   = 1'b1;
            w_tick_nxt  = '0;
        end else if (adj) begin
            w_state_nxt = S_ADJ;
            w_tick_nxt  = '0;
            // The entry cycle only arms the divider; increments start after it.
            if (r_state == S_ADJ) begin
                if (w_adj_eff == ADJ_LAST) begin
                    w_adj_nxt     = '0;
                    w_inc_sec_nxt = sel;
                    w_inc_min_nxt = ~sel;
                end else begin
                    w_adj_nxt = w_adj_eff + AW'(1);
                end
            end
        end else begin
            w_state_nxt = w_paused_nxt ? S_PAUSE : S_RUN;
            // Count only while staying in RUN; pausing freezes the partial second.
            if ((r_state == S_RUN) && !w_pause_tog) begin
                if (r_tick_cnt == TICK_LAST) begin
                    w_tick_nxt    = '0;
                    w_cnt_inc_nxt = 1'b1;
                end else begin
                    w_tick_nxt = r_tick_cnt + TW'(1);
                end
            end else if (r_state == S_ADJ) begin
                w_tick_nxt = '0;
            end
        end
    end

    // Mode state register.
    always_ff @(posedge clkAdj) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_nxt;
    end

    // Pause flag, dividers, sel history and registered strobes.
    always_ff @(posedge clkAdj) begin
        if (rst) begin
            r_paused   <= 1'b0;
            r_tick_cnt <= '0;
            r_adj_cnt  <= '0;
            r_sel_q    <= 1'b0;
            r_cnt_inc  <= 1'b0;
            r_inc_sec  <= 1'b0;
            r_inc_min  <= 1'b0;
            r_clr      <= 1'b0;
        end else begin
            r_paused   <= w_paused_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_adj_cnt  <= w_adj_nxt;
            r_sel_q    <= sel;
            r_cnt_inc  <= w_cnt_inc_nxt;
            r_inc_sec  <= w_inc_sec_nxt;
            r_inc_min  <= w_inc_min_nxt;
            r_clr      <= w_clr_nxt;
        end
    end

    assign state   = r_state;
    assign paused  = r_paused;
    assign cnt_inc = r_cnt_inc;
    assign inc_sec = r_inc_sec;
    assign inc_min = r_inc_min;
    assign clr     = r_clr;

`ifdef STOPWATCH_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic          r_phase;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_min;
    logic          r_blink_sec;
    logic          w_phase_nxt;
    logic [BW-1:0] w_blink_cnt_nxt;

    // Phase runs only while staying in ADJ; any other mode parks it at 0.
    always_comb begin
        w_phase_nxt     = 1'b0;
        w_blink_cnt_nxt = '0;
        if ((r_state == S_ADJ) && (w_state_nxt == S_ADJ)) begin
            if (r_blink_cnt == BLINK_LAST) begin
                w_blink_cnt_nxt = '0;
                w_phase_nxt     = ~r_phase;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + BW'(1);
                w_phase_nxt     = r_phase;
            end
        end
    end

    // Registered blanking of the selected field.
    always_ff @(posedge clkAdj) begin
        if (rst) begin
            r_phase     <= 1'b0;
            r_blink_cnt <= '0;
            r_blink_min <= 1'b0;
            r_blink_sec <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_sec <= w_phase_nxt & sel;
            r_blink_min <= w_phase_nxt & ~sel;
        end
    end

    assign blink_min = r_blink_min;
    assign blink_sec = r_blink_sec;
`else
    assign blink_min = 1'b0;
    assign blink_sec = 1'b0;
`endif

endmodule
